// File: rtl/riscv_ctrl_pkg.sv
// Shared RV32I control encodings: opcodes, multicycle FSM states and datapath mux selects.
package riscv_ctrl_pkg;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE, S_EXECR,
    S_EXECI, S_LUI, S_AUIPC, S_JAL, S_ALUWB, S_BEQ, S_TRAP
  } state_t;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;
  localparam logic [1:0] SRCA_ZERO  = 2'b11;

  localparam logic [1:0] SRCB_REGB  = 2'b00;
  localparam logic [1:0] SRCB_IMM   = 2'b01;
  localparam logic [1:0] SRCB_FOUR  = 2'b10;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;
  localparam logic [2:0] IMM_U = 3'b100;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

endpackage

// File: rtl/multicycle_maindec_instrdec.sv
// instrdec: combinational opcode -> immediate format decoder, reusable by pipelined control.
module instrdec
  import riscv_ctrl_pkg::*;
#(
  parameter int OP_W     = 7,
  parameter int IMMSRC_W = 3
) (
  input  logic [OP_W-1:0]     op,
  output logic [IMMSRC_W-1:0] ImmSrc
);

  always_comb begin
    ImmSrc = IMM_I;
    case (op)
      OP_STORE:         ImmSrc = IMM_S;
      OP_BRANCH:        ImmSrc = IMM_B;
      OP_JAL:           ImmSrc = IMM_J;
      OP_LUI, OP_AUIPC: ImmSrc = IMM_U;
      default:          ImmSrc = IMM_I;
    endcase
  end

endmodule

// File: rtl/multicycle_maindec.sv
// Multicycle RV32I main decoder: Moore FSM with memory wait-state handshake.
// Define MAINDEC_ILLEGAL_TRAP_EN to trap unlisted opcodes (adds IllegalOp); otherwise they retire as nops.
module multicycle_maindec
  import riscv_ctrl_pkg::*;
#(
  parameter int OP_W     = 7,
  parameter int IMMSRC_W = 3,
  parameter int ALUOP_W  = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [OP_W-1:0]     op,
  input  logic                MemReady,
  output logic [IMMSRC_W-1:0] ImmSrc,
  output logic                AdrSrc,
  output logic [1:0]          ALUSrcA,
  output logic [1:0]          ALUSrcB,
  output logic [1:0]          ResultSrc,
  output logic [ALUOP_W-1:0]  ALUOp,
  output logic                IRWrite,
  output logic                PCUpdate,
  output logic                Branch,
  output logic                RegWrite,
  output logic                MemWrite,
  output logic                InstrRetire
`ifdef MAINDEC_ILLEGAL_TRAP_EN
  , output logic              IllegalOp
`endif
);

  state_t r_state, w_next;

  instrdec #(.OP_W(OP_W), .IMMSRC_W(IMMSRC_W)) u_instrdec (
    .op     (op),
    .ImmSrc (ImmSrc)
  );

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_FETCH;
    else       r_state <= w_next;
  end

`ifdef MAINDEC_ILLEGAL_TRAP_EN
  assign IllegalOp = (r_state == S_TRAP);
`endif

  always_comb begin
    w_next      = r_state;
    AdrSrc      = 1'b0;
    ALUSrcA     = SRCA_PC;
    ALUSrcB     = SRCB_REGB;
    ResultSrc   = RES_ALUOUT;
    ALUOp       = ALUOP_ADD;
    IRWrite     = 1'b0;
    PCUpdate    = 1'b0;
    Branch      = 1'b0;
    RegWrite    = 1'b0;
    MemWrite    = 1'b0;
    InstrRetire = 1'b0;
    case (r_state)
      S_FETCH: begin
        ALUSrcB   = SRCB_FOUR;
        ResultSrc = RES_ALURESULT;
        IRWrite   = MemReady;
        PCUpdate  = MemReady;
        if (MemReady) w_next = S_DECODE;
      end
      // ALUOut captures the branch/jump target while the register file is read
      S_DECODE: begin
        ALUSrcA = SRCA_OLDPC;
        ALUSrcB = SRCB_IMM;
        case (op)
          OP_LOAD, OP_STORE: w_next = S_MEMADR;
          OP_RTYPE:          w_next = S_EXECR;
          OP_ITYPE:          w_next = S_EXECI;
          OP_BRANCH:         w_next = S_BEQ;
          OP_JAL:            w_next = S_JAL;
          OP_LUI:            w_next = S_LUI;
          OP_AUIPC:          w_next = S_AUIPC;
          default: begin
`ifdef MAINDEC_ILLEGAL_TRAP_EN
            w_next = S_TRAP;
`else
            w_next      = S_FETCH;
            InstrRetire = 1'b1;
`endif
          end
        endcase
      end
      S_MEMADR: begin
        ALUSrcA = SRCA_RS1;
        ALUSrcB = SRCB_IMM;
        w_next  = (op == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        AdrSrc = 1'b1;
        if (MemReady) w_next = S_MEMWB;
      end
      S_MEMWB: begin
        ResultSrc   = RES_DATA;
        RegWrite    = 1'b1;
        InstrRetire = 1'b1;
        w_next      = S_FETCH;
      end
      S_MEMWRITE: begin
        AdrSrc      = 1'b1;
        MemWrite    = 1'b1;
        InstrRetire = MemReady;
        if (MemReady) w_next = S_FETCH;
      end
      S_EXECR: begin
        ALUSrcA = SRCA_RS1;
        ALUOp   = ALUOP_FUNCT;
        w_next  = S_ALUWB;
      end
      S_EXECI: begin
        ALUSrcA = SRCA_RS1;
        ALUSrcB = SRCB_IMM;
        ALUOp   = ALUOP_FUNCT;
        w_next  = S_ALUWB;
      end
      S_LUI: begin
        ALUSrcA = SRCA_ZERO;
        ALUSrcB = SRCB_IMM;
        w_next  = S_ALUWB;
      end
      S_AUIPC: begin
        ALUSrcA = SRCA_OLDPC;
        ALUSrcB = SRCB_IMM;
        w_next  = S_ALUWB;
      end
      // link value OldPC+4 is computed here while the target in ALUOut loads PC
      S_JAL: begin
        ALUSrcA  = SRCA_OLDPC;
        ALUSrcB  = SRCB_FOUR;
        PCUpdate = 1'b1;
        w_next   = S_ALUWB;
      end
      S_ALUWB: begin
        RegWrite    = 1'b1;
        InstrRetire = 1'b1;
        w_next      = S_FETCH;
      end
      S_BEQ: begin
        ALUSrcA     = SRCA_RS1;
        ALUOp       = ALUOP_SUB;
        Branch      = 1'b1;
        InstrRetire = 1'b1;
        w_next      = S_FETCH;
      end
      S_TRAP:  w_next = S_TRAP;
      default: w_next = S_FETCH;
    endcase
  end

endmodule

// File: doc/multicycle_maindec.md
Name: multicycle_maindec

Overview:
- Next-generation RV32I main decoder for the multicycle datapath; replaces the single-cycle combinational decoder.
- Moore FSM sequencing Fetch/Decode/Execute/Writeback over a shared instruction/data memory, with memory wait-state handshake.
- Adds lui/auipc (U-type immediates) to lw, sw, R-type, I-type ALU, beq and jal.
- Feeds the existing ALU decoder (ALUOp) and the multicycle datapath muxes/enables.

Parameters:
- OP_W, 7, opcode width.
- IMMSRC_W, 3, ImmSrc width: 000 I, 001 S, 010 B, 011 J, 100 U.
- ALUOP_W, 2, ALUOp width: 00 add, 01 sub, 10 funct-decoded.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-high.
- op  in  OP_W  opcode from instruction register.
- MemReady  in  1  memory access completes this cycle.
- ImmSrc  out  IMMSRC_W  immediate format, combinational from op.
- AdrSrc  out  1  0 = PC, 1 = ALUOut.
- ALUSrcA  out  2  00 PC, 01 OldPC, 10 rs1 register A, 11 zero.
- ALUSrcB  out  2  00 register B, 01 ImmExt, 10 constant 4.
- ResultSrc  out  2  00 ALUOut, 01 Data, 10 ALUResult.
- ALUOp  out  ALUOP_W  to ALU decoder.
- IRWrite, PCUpdate, Branch, RegWrite, MemWrite  out  1 each  datapath enables.
- InstrRetire  out  1  single-cycle pulse in each instruction's final state.

Behaviour:
- Reset is synchronous; reset has priority over every transition, including mid-instruction. On reset: state = FETCH; all registered-state outputs take FETCH values with MemReady treated as 0.
- Outputs are decoded from state only, except ImmSrc (decoded from op, 000 for unlisted opcodes) and the MemReady-gated enables.
- Unlisted outputs are 0 in every state.
- FETCH:
  - AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ALUOp=00, ResultSrc=10.
  - IRWrite = PCUpdate = MemReady.
  - Stays in FETCH while !MemReady; goes to DECODE otherwise.
- DECODE: ALUSrcA=01, ALUSrcB=01, ALUOp=00 (branch target into ALUOut). Next state by op:
  - 0000011 or 0100011 -> MEMADR
  - 0110011 -> EXECR
  - 0010011 -> EXECI
  - 1100011 -> BEQ
  - 1101111 -> JAL
  - 0110111 -> LUI
  - 0010111 -> AUIPC
  - other -> ILLEGAL handling (see Optional Feature)
- MEMADR: ALUSrcA=10, ALUSrcB=01, ALUOp=00. Next: MEMREAD for lw, MEMWRITE for sw.
- MEMREAD: AdrSrc=1, ResultSrc=00. Waits for MemReady, then goes to MEMWB.
- MEMWB: ResultSrc=01, RegWrite=1, InstrRetire=1, then FETCH.
- MEMWRITE: AdrSrc=1, ResultSrc=00, MemWrite=1, held until MemReady. InstrRetire=MemReady; goes to FETCH when MemReady.
- EXECR: ALUSrcA=10, ALUSrcB=00, ALUOp=10, then ALUWB.
- EXECI: ALUSrcA=10, ALUSrcB=01, ALUOp=10, then ALUWB.
- LUI: ALUSrcA=11, ALUSrcB=01, ALUOp=00, then ALUWB.
- AUIPC: ALUSrcA=01, ALUSrcB=01, ALUOp=00, then ALUWB.
- JAL: ALUSrcA=01, ALUSrcB=10, ALUOp=00, ResultSrc=00, PCUpdate=1, then ALUWB.
- ALUWB: ResultSrc=00, RegWrite=1, InstrRetire=1, then FETCH.
- BEQ: ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00, Branch=1, InstrRetire=1, then FETCH.
- MemReady is ignored outside FETCH, MEMREAD and MEMWRITE.
- A MemReady held high continuously gives minimum latencies:
  - lw 5 cycles; sw 4 cycles.
  - R-type, I-type, lui, auipc and jal 4 cycles.
  - beq 3 cycles.
- op is sampled only in DECODE and MEMADR; the IR is stable there because IRWrite=0.

Optional Feature:
- Macro: MAINDEC_ILLEGAL_TRAP_EN.
- Defined:
  - An unlisted opcode in DECODE goes to TRAP. TRAP is absorbing (exit only by reset) and holds all enables at 0.
  - Extra port IllegalOp (out, 1) is 1 in TRAP and 0 otherwise.
- Undefined:
  - An unlisted opcode goes DECODE -> FETCH with InstrRetire=1 in DECODE, so it executes as a nop.
  - There is no IllegalOp port.

Decomposition:
- Package riscv_ctrl_pkg holds:
  - opcode constants;
  - state enum;
  - ALUSrcA/ALUSrcB/ResultSrc/ImmSrc/ALUOp encodings.
- One natural sub-module: instrdec, the combinational op-to-ImmSrc decoder, shared with future pipelined control.

Test Plan:
- Reset asserted in MEMREAD -> next cycle state FETCH; IRWrite=0, RegWrite=0, MemWrite=0.
- lw (op=0000011) with MemReady=1 -> states FETCH, DECODE, MEMADR, MEMREAD, MEMWB; RegWrite=1 and ResultSrc=01 only in cycle 5; ImmSrc=000.
- sw with MemReady low for 3 cycles in MEMWRITE -> MemWrite=1 for 4 cycles; InstrRetire pulses once, in the MemReady cycle.
- FETCH with MemReady=0 for 2 cycles -> IRWrite=0 and PCUpdate=0 for 2 cycles, then IRWrite=PCUpdate=1 for one cycle.
- lui (0110111) -> ImmSrc=100; LUI state drives ALUSrcA=11, ALUSrcB=01; RegWrite=1 in cycle 4.
- op=1111111 -> with MAINDEC_ILLEGAL_TRAP_EN: IllegalOp=1 and stuck until reset. Without it: FETCH follows DECODE with InstrRetire=1.
